multicycle_ctrl: RTL

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl_pkg.sv | 30 +++
 rtl/multicycle_ctrl_op_classify.sv | 35 +++
 rtl/multicycle_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared state, opcode-class and opcode constants for multicycle_ctrl.
// MULTICYCLE_CTRL_TRAP_EN in the top selects trap vs. NOP on illegal opcodes.
package multicycle_ctrl_pkg;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd5;

    typedef enum logic [2:0] {
        C_LOAD,
        C_STORE,
        C_STRI,
        C_BOZ,
        C_BRA,
        C_COMP,
        C_ALU,
        C_ILL
    } op_class_t;

    localparam logic [3:0] OP_LOAD  = 4'd0;
    localparam logic [3:0] OP_STORE = 4'd2;
    localparam logic [3:0] OP_STRI  = 4'd4;
    localparam logic [3:0] OP_BOZ   = 4'd6;
    localparam logic [3:0] OP_BRA   = 4'd8;
    localparam logic [3:0] OP_COMP  = 4'd10;

endpackage

// File: rtl/multicycle_ctrl_op_classify.sv
// Combinational opcode -> instruction class decoder.
// Any set bit above bit 3 makes the opcode illegal.
module op_classify
    import multicycle_ctrl_pkg::*;
#(
    parameter int OP_W = 4
) (
    input  logic [OP_W-1:0] opcode,
    output op_class_t       cls,
    output logic            illegal
);

    logic [3:0] lo;
    logic       legal;

    assign lo    = opcode[3:0];
    assign legal = ((opcode >> 4) == '0);

    always_comb begin
        cls = C_ILL;
        unique case (1'b1)
            legal & lo[0]:             cls = C_ALU;
            legal & (lo == OP_LOAD):   cls = C_LOAD;
            legal & (lo == OP_STORE):  cls = C_STORE;
            legal & (lo == OP_STRI):   cls = C_STRI;
            legal & (lo == OP_BOZ):    cls = C_BOZ;
            legal & (lo == OP_BRA):    cls = C_BRA;
            legal & (lo == OP_COMP):   cls = C_COMP;
            default:                   cls = C_ILL;
        endcase
    end

    assign illegal = (cls == C_ILL);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB controller with retired counter.
// Define MULTICYCLE_CTRL_TRAP_EN to trap on illegal opcodes (else NOP).
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int OP_W  = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [OP_W-1:0]  opcode,
    input  logic             zero_flag,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_r,
    output logic             mem_w,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             alu_src,
    output logic             ir_valid,
    output logic [CNT_W-1:0] retired,
    output logic             busy
);

    logic [2:0] state;
    logic [2:0] nxt;
    logic       run;
    op_class_t  cls_q;
    op_class_t  cls_d;
    logic       ill_d;

    op_classify #(.OP_W(OP_W)) u_cls (
        .opcode  (opcode),
        .cls     (cls_d),
        .illegal (ill_d)
    );

    logic st_exec, st_mem, st_wb;
    logic in_f, f_ack, take;
    logic is_ls, is_rd, retire;

    assign st_exec = (state == S_EXEC);
    assign st_mem  = (state == S_MEM);
    assign st_wb   = (state == S_WB);

    // FETCH only requests once the first post-reset edge has set run
    assign in_f  = (state == S_FETCH) & run;
    assign f_ack = in_f & mem_ack;

    assign is_ls = (cls_q == C_LOAD) | (cls_q == C_STORE)
                 | (cls_q == C_STRI);
    assign is_rd = (cls_q == C_COMP) | (cls_q == C_ALU);
    assign take  = (cls_q == C_BRA)
                 | ((cls_q == C_BOZ) & zero_flag);

    assign mem_req   = in_f | st_mem;
    assign mem_r     = in_f | (st_mem & (cls_q == C_LOAD));
    assign mem_w     = st_mem & (cls_q == C_STORE);
    assign ir_write  = f_ack;
    assign pc_write  = f_ack | (st_exec & take);
    assign pc_src    = st_exec & take;
    assign alu_src   = st_exec & is_ls;
    assign reg_dst   = (st_exec | st_wb) & is_rd;
    assign reg_write = st_wb;
    assign busy      = run;

    always_comb begin
        nxt = state;
        case (state)
            S_FETCH:  if (f_ack) nxt = S_DECODE;
            S_DECODE: begin
                if (ill_d) begin
`ifdef MULTICYCLE_CTRL_TRAP_EN
                    nxt = S_TRAP;
`else
                    nxt = S_FETCH;
`endif
                end else begin
                    nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                case (cls_q)
                    C_LOAD, C_STORE: nxt = S_MEM;
                    C_BOZ, C_BRA:    nxt = S_FETCH;
                    default:         nxt = S_WB;
                endcase
            end
            S_MEM: begin
                if (mem_ack)
                    nxt = (cls_q == C_LOAD) ? S_WB : S_FETCH;
            end
            S_WB:    nxt = S_FETCH;
            S_TRAP:  nxt = S_TRAP;
            default: nxt = S_FETCH;
        endcase
    end

    // DECODE -> FETCH only happens for the NOP case, which also retires
    assign retire = (nxt == S_FETCH) & (state != S_FETCH)
                  & (state != S_TRAP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_FETCH;
            run      <= 1'b0;
            cls_q    <= C_ILL;
            ir_valid <= 1'b0;
            retired  <= '0;
        end else begin
            run   <= 1'b1;
            state <= nxt;
            if (state == S_DECODE)
                cls_q <= cls_d;
            if (f_ack)
                ir_valid <= 1'b1;
            if (retire)
                retired <= retired + CNT_W'(1);
        end
    end

endmodule
